// File: rtl/exp_stream_pipe_if.sv
// rtl/exp_stream_pipe_if.sv - operand/result stream bundle for the exp pipeline
interface exp_stream_pipe_if;
    logic [31:0] exp_data_i;
    logic        exp_data_valid_i;
    logic        exp_ready_o;
    logic [31:0] exp_data_o;
    logic        exp_data_valid_o;
    logic        exp_ready_i;
    logic        exp_last_o;
    logic        exp_done_o;
    logic        exp_range_err_o;

    modport slave (
        input  exp_data_i, exp_data_valid_i, exp_ready_i,
        output exp_ready_o, exp_data_o, exp_data_valid_o,
               exp_last_o, exp_done_o, exp_range_err_o
    );

    modport master (
        output exp_data_i, exp_data_valid_i, exp_ready_i,
        input  exp_ready_o, exp_data_o, exp_data_valid_o,
               exp_last_o, exp_done_o, exp_range_err_o
    );
endinterface

// File: rtl/exp_stream_pipe.sv
// rtl/exp_stream_pipe.sv - 4-stage streaming FP32 e^x (x <= 0) with frame tracking
module exp_stream_pipe #(
    parameter int NUM_DATA      = 10,
    parameter int FRAC_BITS     = 16,
    parameter int LUT_ADDR_BITS = 8
) (
    input  logic            clock_i,
    input  logic            reset_n_i,
    exp_stream_pipe_if.slave bus
);

    localparam int MAG_W  = FRAC_BITS + 7;
    localparam int T_W    = FRAC_BITS + 8;
    localparam int WIDE_W = FRAC_BITS + 24;
    localparam int PROD_W = MAG_W + 23;
    localparam int CNT_W  = $clog2(NUM_DATA + 1);
    localparam int LUT_N  = 1 << LUT_ADDR_BITS;
    localparam logic [22:0]      LOG2E_Q22 = 23'h5C551E;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_DATA - 1);

    typedef enum logic [1:0] {CL_NORM, CL_ONE, CL_UNDER, CL_NAN} cls_t;

    // 2^(2^-j) in Q1.30; the fraction table is built from products of these,
    // so address widths up to 8 bits are covered exactly.
    function automatic logic [63:0] root_q30(input int j);
        case (j)
            1:       return 64'd1518500250;
            2:       return 64'd1276901417;
            3:       return 64'd1170923762;
            4:       return 64'd1121280437;
            5:       return 64'd1097253708;
            6:       return 64'd1085434106;
            7:       return 64'd1079572136;
            8:       return 64'd1076653033;
            default: return 64'd1073741824;
        endcase
    endfunction

    // round((2^(k/2^LUT_ADDR_BITS) - 1) * 2^23)
    function automatic logic [22:0] exp2_frac(input int k);
        logic [63:0] acc;
        acc = 64'd1 << 30;
        for (int j = 1; j <= LUT_ADDR_BITS; j++) begin
            if (k[LUT_ADDR_BITS-j])
                acc = (acc * root_q30(j) + (64'd1 << 29)) >> 30;
        end
        return 23'((acc - (64'd1 << 30) + 64'd64) >> 7);
    endfunction

    logic [22:0] lut_rom [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        localparam logic [22:0] ENTRY = exp2_frac(k);
        assign lut_rom[k] = ENTRY;
    end

    logic stall, adv, in_xfer, out_xfer;

    logic              s1_valid, s1_last;
    cls_t              s1_cls;
    logic [MAG_W-1:0]  s1_mag;
    logic              s2_valid, s2_last;
    cls_t              s2_cls;
    logic [T_W-1:0]    s2_t;
    logic              s3_valid, s3_last;
    cls_t              s3_cls;
    logic [9:0]        s3_exp;
    logic [22:0]       s3_frac;
    logic              out_valid_q, out_last_q, done_q, err_q;
    logic [31:0]       out_data_q;
    logic [CNT_W-1:0]  in_cnt, out_cnt;

    assign stall    = out_valid_q && !bus.exp_ready_i;
    assign adv      = !stall;
    assign in_xfer  = bus.exp_data_valid_i && adv;
    assign out_xfer = out_valid_q && bus.exp_ready_i;

    logic              in_sign;
    logic [7:0]        in_exp;
    logic [22:0]       in_man;
    logic [WIDE_W-1:0] in_wide;
    logic [MAG_W-1:0]  in_mag;
    cls_t              in_cls;
    logic              in_flag;

    assign in_sign = bus.exp_data_i[31];
    assign in_exp  = bus.exp_data_i[30:23];
    assign in_man  = bus.exp_data_i[22:0];
    assign in_wide = {1'b1, in_man, {FRAC_BITS{1'b0}}} >> (8'd150 - in_exp);

    // S1 classify the operand and convert |x| to Q7.FRAC_BITS
    always_comb begin
        in_cls  = CL_NORM;
        in_flag = 1'b0;
        in_mag  = MAG_W'(in_wide);
        if (in_exp == 8'd0) begin
            in_cls = CL_ONE;
            in_mag = '0;
        end else if (in_exp == 8'hFF && in_man != 23'd0) begin
            in_cls  = CL_NAN;
            in_flag = 1'b1;
            in_mag  = '0;
        end else if (!in_sign) begin
            in_cls  = CL_ONE;
            in_flag = 1'b1;
            in_mag  = '0;
        end else if (in_exp >= 8'd134) begin
            in_cls = CL_UNDER;
            in_mag = '0;
        end else if (in_mag == '0) begin
            in_cls = CL_ONE;
        end
    end

    // S1 register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_cls   <= CL_NORM;
            s1_mag   <= '0;
        end else if (adv) begin
            s1_valid <= bus.exp_data_valid_i;
            s1_last  <= (in_cnt == CNT_LAST);
            s1_cls   <= in_cls;
            s1_mag   <= in_mag;
        end
    end

    logic [PROD_W-1:0] prod;
    assign prod = {{23{1'b0}}, s1_mag} * {{MAG_W{1'b0}}, LOG2E_Q22};

    // S2 t = |x| * log2(e), truncated to Q8.FRAC_BITS
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_cls   <= CL_NORM;
            s2_t     <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_cls   <= s1_cls;
            s2_t     <= T_W'(prod >> 22);
        end
    end

    logic [7:0]               t_int;
    logic [FRAC_BITS-1:0]     t_frac;
    logic [FRAC_BITS:0]       r_full;
    logic [LUT_ADDR_BITS-1:0] lut_idx;
    logic [9:0]               exp_next;

    // 2^-t = 2^-(ti+1) * 2^(1-tf) when tf != 0, so borrow one from the exponent
    assign t_int    = s2_t[T_W-1:FRAC_BITS];
    assign t_frac   = s2_t[FRAC_BITS-1:0];
    assign r_full   = {1'b1, {FRAC_BITS{1'b0}}} - {1'b0, t_frac};
    assign lut_idx  = (t_frac == '0) ? '0
                    : LUT_ADDR_BITS'(r_full >> (FRAC_BITS - LUT_ADDR_BITS));
    assign exp_next = 10'd127 - {2'b00, t_int} - {9'd0, (t_frac != '0)};

    // S3 exponent split and registered fraction-table read
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_cls   <= CL_NORM;
            s3_exp   <= '0;
            s3_frac  <= '0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
            s3_cls   <= s2_cls;
            s3_exp   <= exp_next;
            s3_frac  <= lut_rom[lut_idx];
        end
    end

    logic [31:0] asm_data;

    // S4 assemble the FP32 result; a non-positive exponent flushes to zero
    always_comb begin
        asm_data = {1'b0, s3_exp[7:0], s3_frac};
        case (s3_cls)
            CL_NAN:   asm_data = 32'h7FC00000;
            CL_ONE:   asm_data = 32'h3F800000;
            CL_UNDER: asm_data = 32'h00000000;
            default: begin
                if (s3_exp[9] || s3_exp == 10'd0)
                    asm_data = 32'h00000000;
            end
        endcase
    end

    // S4 output register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            out_valid_q <= s3_valid;
            out_last_q  <= s3_last;
            out_data_q  <= asm_data;
        end
    end

    // Frame counters, completion pulse and sticky range error
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (in_xfer)
                in_cnt <= (in_cnt == CNT_LAST) ? '0 : in_cnt + 1'b1;
            if (out_xfer)
                out_cnt <= (out_cnt == CNT_LAST) ? '0 : out_cnt + 1'b1;
            done_q <= out_xfer && out_last_q;
            if (in_xfer && in_flag)
                err_q <= 1'b1;
        end
    end

    assign bus.exp_ready_o      = adv;
    assign bus.exp_data_o       = out_data_q;
    assign bus.exp_data_valid_o = out_valid_q;
    assign bus.exp_last_o       = out_last_q;
    assign bus.exp_done_o       = done_q;
    assign bus.exp_range_err_o  = err_q;

endmodule

// File: tb/tb_exp_stream_pipe.sv
// tb/tb_exp_stream_pipe.sv - scoreboard bench for exp_stream_pipe
module tb_exp_stream_pipe;
    localparam int NUM = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exp_stream_pipe_if bus_if();

    exp_stream_pipe #(.NUM_DATA(NUM), .FRAC_BITS(16), .LUT_ADDR_BITS(8)) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus_if)
    );

    typedef struct {
        bit          exact;
        logic [31:0] bits;
        real         val;
        bit          last;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int in_idx = 0;
    int done_seen = 0;
    int stall_seen = 0;
    int out_seen = 0;

    function automatic real fp_to_real(input logic [31:0] b);
        real v;
        v = (1.0 + real'(b[22:0]) / 8388608.0) * $pow(2.0, real'(b[30:23]) - 127.0);
        return b[31] ? -v : v;
    endfunction

    function automatic exp_t model(input logic [31:0] x, input bit last);
        exp_t r;
        real v;
        r.exact = 1'b1;
        r.val   = 0.0;
        r.last  = last;
        r.bits  = 32'h0;
        if (x[30:23] == 8'h00)                       r.bits = 32'h3F800000;
        else if (x[30:23] == 8'hFF && x[22:0] != 0)  r.bits = 32'h7FC00000;
        else if (!x[31])                             r.bits = 32'h3F800000;
        else if (x[30:23] == 8'hFF)                  r.bits = 32'h00000000;
        else begin
            v = -fp_to_real(x);
            if (v >= 89.0) r.bits = 32'h00000000;
            else begin
                r.exact = 1'b0;
                r.val   = $exp(-v);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_neg();
        logic [7:0]  e;
        logic [31:0] m;
        e = 8'($urandom_range(100, 132));
        m = $urandom;
        return {1'b1, e, m[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic check_close(input string name, input logic [31:0] act, input real want);
        real a;
        bit ok;
        checks++;
        ok = 1'b0;
        if (!act[31] && act[30:23] != 8'h00 && act[30:23] != 8'hFF) begin
            a  = fp_to_real(act);
            ok = ((a > want) ? a - want : want - a) <= want / 128.0;
        end
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h want approx %g", name, act, want);
        end
    endtask

    // output monitor: pops the scoreboard on every output transfer
    initial begin
        bit prev_stall;
        bit prev_last_xfer;
        logic [31:0] prev_data;
        exp_t e;
        prev_stall = 1'b0;
        prev_last_xfer = 1'b0;
        prev_data = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_last_xfer = 1'b0;
            end else begin
                check("done", {31'd0, bus_if.exp_done_o}, {31'd0, prev_last_xfer});
                if (prev_stall) begin
                    check("hold_valid", {31'd0, bus_if.exp_data_valid_o}, 32'd1);
                    check("hold_data", bus_if.exp_data_o, prev_data);
                end
                if (bus_if.exp_data_valid_o && !bus_if.exp_ready_i) begin
                    check("ready_in_stall", {31'd0, bus_if.exp_ready_o}, 32'd0);
                    stall_seen++;
                end
                prev_last_xfer = 1'b0;
                if (bus_if.exp_data_valid_o && bus_if.exp_ready_i) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h want none", bus_if.exp_data_o);
                    end else begin
                        e = sb.pop_front();
                        if (e.exact) check("data", bus_if.exp_data_o, e.bits);
                        else         check_close("data_tol", bus_if.exp_data_o, e.val);
                        check("last", {31'd0, bus_if.exp_last_o}, {31'd0, e.last});
                        prev_last_xfer = bus_if.exp_last_o;
                    end
                    out_seen++;
                end
                if (bus_if.exp_done_o) done_seen++;
                prev_stall = bus_if.exp_data_valid_o && !bus_if.exp_ready_i;
                prev_data  = bus_if.exp_data_o;
            end
        end
    end

    // called at #1 after a rising edge; returns #1 after the accepting edge
    task automatic send(input logic [31:0] x);
        bit ok;
        ok = 1'b0;
        bus_if.exp_data_i = x;
        bus_if.exp_data_valid_i = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (bus_if.exp_ready_o) begin
                sb.push_back(model(x, in_idx == NUM - 1));
                in_idx = (in_idx + 1) % NUM;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus_if.exp_data_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept want accept");
        end
    endtask

    task automatic drain();
        for (int w = 0; w < 500 && sb.size() != 0; w++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, bus_if.exp_data_valid_o}, 32'd0);
        check("rst_data", bus_if.exp_data_o, 32'd0);
        check("rst_last", {31'd0, bus_if.exp_last_o}, 32'd0);
        check("rst_done", {31'd0, bus_if.exp_done_o}, 32'd0);
        check("rst_err", {31'd0, bus_if.exp_range_err_o}, 32'd0);
        sb.delete();
        in_idx = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, bus_if.exp_ready_o}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int s0, o0, d0;
        bit stream_done;
        bus_if.exp_data_i = 32'h0;
        bus_if.exp_data_valid_i = 1'b0;
        bus_if.exp_ready_i = 1'b1;

        do_reset();

        // zeros and latency
        send(32'h00000000);
        lat = 1;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus_if.exp_data_valid_o) break;
            @(posedge clk);
            lat++;
        end
        check("latency", lat, 32'd4);
        @(posedge clk);
        #1;
        send(32'h80000000);
        drain();
        check("err_after_zero", {31'd0, bus_if.exp_range_err_o}, 32'd0);

        // values and underflow
        send(32'hBF800000);
        send(32'hC0200000);
        send(32'hC2C80000);
        send(32'hFF800000);
        drain();
        check("err_after_neg", {31'd0, bus_if.exp_range_err_o}, 32'd0);

        // positive operand, sticky error, NaN
        send(32'h40000000);
        drain();
        check("err_pos", {31'd0, bus_if.exp_range_err_o}, 32'd1);
        send(32'hBF800000);
        drain();
        check("err_sticky", {31'd0, bus_if.exp_range_err_o}, 32'd1);
        send(32'h7FC00001);
        drain();
        do_reset();

        // back-pressure for 3 cycles mid-stream
        s0 = stall_seen;
        o0 = out_seen;
        fork
            begin
                for (int i = 0; i < 10; i++) send(rand_neg());
            end
            begin
                repeat (7) @(posedge clk);
                #1 bus_if.exp_ready_i = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus_if.exp_ready_i = 1'b1;
            end
        join
        drain();
        check("stall_cycles", stall_seen - s0, 32'd3);
        check("bp_outputs", out_seen - o0, 32'd10);

        // two frames back-to-back
        do_reset();
        d0 = done_seen;
        for (int i = 0; i < 2 * NUM; i++) send(rand_neg());
        drain();
        check("done_pulses", done_seen - d0, 32'd2);

        // reset with two elements in flight
        bus_if.exp_ready_i = 1'b0;
        send(rand_neg());
        send(rand_neg());
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus_if.exp_data_valid_o) break;
        end
        check("inflight_valid", {31'd0, bus_if.exp_data_valid_o}, 32'd1);
        do_reset();
        bus_if.exp_ready_i = 1'b1;
        d0 = done_seen;
        for (int i = 0; i < NUM - 1; i++) send(rand_neg());
        drain();
        check("no_early_done", done_seen - d0, 32'd0);
        send(rand_neg());
        drain();
        check("done_after_frame", done_seen - d0, 32'd1);

        // random mix with random back-pressure
        stream_done = 1'b0;
        fork
            begin
                logic [31:0] x;
                for (int i = 0; i < 40; i++) begin
                    case ($urandom_range(0, 7))
                        0:       x = 32'h80000000;
                        1:       x = 32'hFF800000;
                        2:       x = 32'hC3480000;
                        default: x = rand_neg();
                    endcase
                    send(x);
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1 bus_if.exp_ready_i = ($urandom_range(0, 3) != 0);
                end
                bus_if.exp_ready_i = 1'b1;
            end
        join
        drain();
        check("err_final", {31'd0, bus_if.exp_range_err_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
